// File: rtl/unison_pkg.sv
// unison_pkg: definitions shared by the unison readout serialiser (core side)
// and deserialiser (RISC side): FSM state encoding, default count width and
// lane ordering inside the packed result word.
package unison_pkg;

   // Readout framing states. The receiver exposes the current value on a debug port.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_SKIP  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Default number of count bits shifted per lane per window.
   localparam int COUNT_W_DEF = 16;

   // Lane groups in the packed result word: all I lanes first (I0 in the LSBs),
   // then all Q lanes.
   localparam int LANE_I_GRP = 0;
   localparam int LANE_Q_GRP = 1;

   // Slot index of (group, core) in the packed result word.
   function automatic int lane_slot(input int grp, input int core, input int n_cores);
      return grp * n_cores + core;
   endfunction

endpackage

// File: rtl/unison_lane_deser.sv
// unison_lane_deser: one serial readout lane. MSB-first shift register plus,
// when UNISON_RX_PARITY_EN is defined, a running XOR over every received bit
// (data and the trailing parity bit). Clear/enable timing is owned by the
// receiver FSM in unison_readout_rx.
module unison_lane_deser
   import unison_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic               clk_master,
   input  logic               rstb,
   input  logic               clr,
   input  logic               shift_en,
`ifdef UNISON_RX_PARITY_EN
   input  logic               par_en,
   output logic               par_acc,
`endif
   input  logic               bit_in,
   output logic [COUNT_W-1:0] shreg
);

   // Shift register: cleared before each frame, shifts MSB-first while enabled.
   always_ff @(posedge clk_master) begin
      if (!rstb) begin
         shreg <= '0;
      end else if (clr) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= {shreg[COUNT_W-2:0], bit_in};
      end
   end

`ifdef UNISON_RX_PARITY_EN
   // Even-parity accumulator: ends at 0 when data plus parity bit are consistent.
   always_ff @(posedge clk_master) begin
      if (!rstb) begin
         par_acc <= 1'b0;
      end else if (clr) begin
         par_acc <= 1'b0;
      end else if (par_en) begin
         par_acc <= par_acc ^ bit_in;
      end
   end
`endif

endmodule

// File: rtl/unison_readout_rx.sv
// unison_readout_rx: RISC-side receiver for the unison read_out_I/read_out_Q bus.
// Detects the end of each integration window (ud_en fall), skips START_DLY
// cycles, deserialises all I/Q lanes in parallel and presents one frame per
// window on a registered valid/ready output with sticky overrun detection.
// Optional feature macro: UNISON_RX_PARITY_EN (one even-parity bit per lane
// after the LSB, sticky parity_err output).
//
// Handshake: rd_valid/rd_data form a valid/ready source. A frame transfers on
// any cycle with rd_valid & rd_ready. Once raised, rd_valid stays high and
// rd_data stays stable until that transfer; a frame completing while the
// previous one is still unread is dropped and flagged on overrun.
module unison_readout_rx
   import unison_pkg::*;
#(
   parameter int N_CORES   = 2,
   parameter int COUNT_W   = COUNT_W_DEF,
   parameter int START_DLY = 2
) (
   input  logic                           clk_master,
   input  logic                           rstb,
   input  logic                           ud_en,
   input  logic [N_CORES-1:0]             read_out_I,
   input  logic [N_CORES-1:0]             read_out_Q,
   output logic [2*N_CORES*COUNT_W-1:0]   rd_data,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [7:0]                     frame_cnt,
   output logic                           overrun,
   output logic                           busy,
`ifdef UNISON_RX_PARITY_EN
   output logic                           parity_err,
`endif
   output state_e                         state_dbg
);

   localparam int N_LANES = 2 * N_CORES;
`ifdef UNISON_RX_PARITY_EN
   localparam int NBITS = COUNT_W + 1;
`else
   localparam int NBITS = COUNT_W;
`endif
   localparam int BIT_W = $clog2(NBITS + 1);

   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);
   localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(COUNT_W);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [3:0]       SKIP_LAST = (START_DLY > 0) ? 4'(START_DLY - 1) : 4'd0;

   state_e                       state, state_n;
   logic                         ud_en_q;
   logic                         fall;
   logic [3:0]                   skip_cnt;
   logic [BIT_W-1:0]             bit_cnt;
   logic                         lane_clr;
   logic                         lane_shift;
   logic [N_LANES-1:0]           lane_bits;
   logic [N_LANES*COUNT_W-1:0]   shregs;
`ifdef UNISON_RX_PARITY_EN
   logic [N_LANES-1:0]           par_vec;
`endif

   assign fall       = ud_en_q & ~ud_en;
   assign busy       = (state == ST_SKIP) || (state == ST_SHIFT);
   assign state_dbg  = state;
   assign lane_clr   = (state == ST_ARM) || (state == ST_SKIP);
   assign lane_shift = (state == ST_SHIFT) && (bit_cnt < DATA_BITS);

   // State register and window-edge history.
   always_ff @(posedge clk_master) begin
      if (!rstb) begin
         state   <= ST_IDLE;
         ud_en_q <= 1'b0;
      end else begin
         state   <= state_n;
         ud_en_q <= ud_en;
      end
   end

   // Next-state logic; a re-raised ud_en during SKIP/SHIFT aborts the frame.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (ud_en) state_n = ST_ARM;
         ST_ARM:   if (fall) state_n = (START_DLY > 0) ? ST_SKIP : ST_SHIFT;
         ST_SKIP:  begin
            if (ud_en)                      state_n = ST_ARM;
            else if (skip_cnt == SKIP_LAST) state_n = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (ud_en)                     state_n = ST_ARM;
            else if (bit_cnt == BIT_LAST)  state_n = ST_DONE;
         end
         ST_DONE:  state_n = ud_en ? ST_ARM : ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Skip and bit counters run only in their own state and restart from 0 on entry.
   always_ff @(posedge clk_master) begin
      if (!rstb) begin
         skip_cnt <= 4'd0;
         bit_cnt  <= '0;
      end else begin
         skip_cnt <= (state == ST_SKIP)  ? skip_cnt + 4'd1 : 4'd0;
         bit_cnt  <= (state == ST_SHIFT) ? bit_cnt + BIT_ONE : '0;
      end
   end

   // Lane k of the packed word: I lanes then Q lanes, matching rd_data layout.
   for (genvar k = 0; k < N_CORES; k++) begin : g_lane_map
      localparam int SLOT_I = lane_slot(LANE_I_GRP, k, N_CORES);
      localparam int SLOT_Q = lane_slot(LANE_Q_GRP, k, N_CORES);
      assign lane_bits[SLOT_I] = read_out_I[k];
      assign lane_bits[SLOT_Q] = read_out_Q[k];
   end

   for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      unison_lane_deser #(
         .COUNT_W (COUNT_W)
      ) u_lane (
         .clk_master (clk_master),
         .rstb       (rstb),
         .clr        (lane_clr),
         .shift_en   (lane_shift),
`ifdef UNISON_RX_PARITY_EN
         .par_en     (state == ST_SHIFT),
         .par_acc    (par_vec[l]),
`endif
         .bit_in     (lane_bits[l]),
         .shreg      (shregs[l*COUNT_W +: COUNT_W])
      );
   end

   // Output register: frame commit in DONE, handshake-driven release elsewhere.
   always_ff @(posedge clk_master) begin
      if (!rstb) begin
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         frame_cnt  <= 8'd0;
         overrun    <= 1'b0;
`ifdef UNISON_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else if (state == ST_DONE) begin
         if (!rd_valid || rd_ready) begin
            rd_data   <= shregs;
            rd_valid  <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
         end else begin
            overrun   <= 1'b1;
         end
`ifdef UNISON_RX_PARITY_EN
         if (|par_vec) parity_err <= 1'b1;
`endif
      end else if (rd_valid && rd_ready) begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_unison_readout_rx.sv
// tb_unison_readout_rx: directed bench for unison_readout_rx with N_CORES=2,
// COUNT_W=16, START_DLY=2. Honours UNISON_RX_PARITY_EN when defined.
module tb_unison_readout_rx;
   import unison_pkg::*;

   localparam int W  = 16;
   localparam int SD = 2;
`ifdef UNISON_RX_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic        clk_master = 1'b0;
   logic        rstb       = 1'b0;
   logic        ud_en      = 1'b0;
   logic        rd_ready   = 1'b1;
   logic [1:0]  read_out_I = 2'b00;
   logic [1:0]  read_out_Q = 2'b00;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic [7:0]  frame_cnt;
   logic        overrun;
   logic        busy;
   state_e      state_dbg;
`ifdef UNISON_RX_PARITY_EN
   logic        parity_err;
`endif

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int fall_cyc = 0;

   logic [15:0] r0, r1, r2, r3;
   logic [63:0] exp_data;

   unison_readout_rx #(
      .N_CORES   (2),
      .COUNT_W   (W),
      .START_DLY (SD)
   ) dut (
      .clk_master (clk_master),
      .rstb       (rstb),
      .ud_en      (ud_en),
      .read_out_I (read_out_I),
      .read_out_Q (read_out_Q),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .frame_cnt  (frame_cnt),
      .overrun    (overrun),
      .busy       (busy),
`ifdef UNISON_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .state_dbg  (state_dbg)
   );

   // Clock
   always #5 clk_master = ~clk_master;

   // One clock: outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_master);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rstb       = 1'b0;
      ud_en      = 1'b0;
      read_out_I = 2'b00;
      read_out_Q = 2'b00;
      tick();
      rstb = 1'b1;
   endtask

   // Open a window, close it, skip START_DLY cycles, then send nbits of each
   // lane MSB-first. A full frame (nbits==W) leaves the DUT in DONE, with the
   // commit happening on the caller's next tick.
   task automatic send_frame(input logic [15:0] i0, input logic [15:0] i1,
                             input logic [15:0] q0, input logic [15:0] q1,
                             input int nbits, input bit flip_q1);
      ud_en = 1'b1;
      tick();
      tick();
      ud_en = 1'b0;
      tick();
      fall_cyc = cyc;
      repeat (SD) tick();
      for (int b = 0; b < nbits; b++) begin
         int idx;
         idx = W - 1 - b;
         read_out_I = {i1[idx], i0[idx]};
         read_out_Q = {q1[idx], q0[idx]};
         tick();
      end
`ifdef UNISON_RX_PARITY_EN
      if (nbits == W) begin
         read_out_I = {^i1, ^i0};
         read_out_Q = {(^q1) ^ flip_q1, ^q0};
         tick();
      end
`else
      if (flip_q1) read_out_Q = 2'b00;
`endif
      read_out_I = 2'b00;
      read_out_Q = 2'b00;
   endtask

   initial begin
      // Reset state
      rstb = 1'b0;
      tick();
      tick();
      check("rst_rd_data",   rd_data, 64'h0);
      check("rst_rd_valid",  64'(rd_valid), 64'h0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
      check("rst_overrun",   64'(overrun), 64'h0);
      check("rst_busy",      64'(busy), 64'h0);
      check("rst_state",     64'(state_dbg), 64'(ST_IDLE));
`ifdef UNISON_RX_PARITY_EN
      check("rst_parity_err", 64'(parity_err), 64'h0);
`endif
      rstb = 1'b1;

      // Single frame with latency check
      send_frame(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000, W, 1'b0);
      check("single_pre_valid", 64'(rd_valid), 64'h0);
      check("single_state_done", 64'(state_dbg), 64'(ST_DONE));
      tick();
      check("single_valid",   64'(rd_valid), 64'h1);
      check("single_latency", 64'(cyc - fall_cyc), 64'(SD + NB + 1));
      check("single_data",    rd_data, 64'h8000_FFFF_0001_A5C3);
      check("single_cnt",     64'(frame_cnt), 64'h1);
      check("single_idle",    64'(state_dbg), 64'(ST_IDLE));
      tick();
      check("single_handshake", 64'(rd_valid), 64'h0);
      check("single_data_hold", rd_data, 64'h8000_FFFF_0001_A5C3);

      // Reset in the middle of SHIFT
      send_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 5, 1'b0);
      check("midshift_busy",  64'(busy), 64'h1);
      check("midshift_state", 64'(state_dbg), 64'(ST_SHIFT));
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      check("midrst_data",    rd_data, 64'h0);
      check("midrst_valid",   64'(rd_valid), 64'h0);
      check("midrst_cnt",     64'(frame_cnt), 64'h0);
      check("midrst_busy",    64'(busy), 64'h0);
      check("midrst_state",   64'(state_dbg), 64'(ST_IDLE));

      // Overrun: second frame dropped while the first is unread
      rd_ready = 1'b0;
      send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, W, 1'b0);
      tick();
      check("ovr_first_valid", 64'(rd_valid), 64'h1);
      check("ovr_first_cnt",   64'(frame_cnt), 64'h1);
      send_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, W, 1'b0);
      tick();
      check("ovr_flag",       64'(overrun), 64'h1);
      check("ovr_data_kept",  rd_data, 64'h4444_3333_2222_1111);
      check("ovr_cnt",        64'(frame_cnt), 64'h1);
      check("ovr_valid_held", 64'(rd_valid), 64'h1);
      rd_ready = 1'b1;
      tick();
      check("ovr_release",    64'(rd_valid), 64'h0);
      check("ovr_sticky",     64'(overrun), 64'h1);

      // Handshake in the DONE cycle lets the second frame through
      do_reset();
      rd_ready = 1'b0;
      send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, W, 1'b0);
      tick();
      send_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, W, 1'b0);
      rd_ready = 1'b1;
      tick();
      check("done_hs_data",    rd_data, 64'h8888_7777_6666_5555);
      check("done_hs_cnt",     64'(frame_cnt), 64'h2);
      check("done_hs_overrun", 64'(overrun), 64'h0);
      check("done_hs_valid",   64'(rd_valid), 64'h1);
      tick();
      check("done_hs_release", 64'(rd_valid), 64'h0);

      // Abort after 5 data bits, then a clean window
      send_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 5, 1'b0);
      ud_en = 1'b1;
      tick();
      check("abort_state", 64'(state_dbg), 64'(ST_ARM));
      check("abort_valid", 64'(rd_valid), 64'h0);
      check("abort_cnt",   64'(frame_cnt), 64'h2);
      check("abort_data",  rd_data, 64'h8888_7777_6666_5555);
      send_frame(16'h0F0F, 16'h7E57, 16'h0000, 16'hABCD, W, 1'b0);
      tick();
      check("after_abort_data",  rd_data, 64'hABCD_0000_7E57_0F0F);
      check("after_abort_cnt",   64'(frame_cnt), 64'h3);
      check("after_abort_valid", 64'(rd_valid), 64'h1);

      // 256 frames back to back: frame_cnt wraps to 0, nothing dropped
      do_reset();
      for (int k = 0; k < 256; k++) begin
         r0 = 16'($urandom_range(0, 65535));
         r1 = 16'($urandom_range(0, 65535));
         r2 = 16'($urandom_range(0, 65535));
         r3 = 16'($urandom_range(0, 65535));
         exp_data = {r3, r2, r1, r0};
         send_frame(r0, r1, r2, r3, W, 1'b0);
         ud_en = 1'b1;
         tick();
         check("wrap_cnt",  64'(frame_cnt), 64'((k + 1) % 256));
         check("wrap_data", rd_data, exp_data);
      end
      check("wrap_final_cnt", 64'(frame_cnt), 64'h0);
      check("wrap_overrun",   64'(overrun), 64'h0);
      check("wrap_rearm",     64'(state_dbg), 64'(ST_ARM));

`ifdef UNISON_RX_PARITY_EN
      // Parity: clean frame keeps parity_err low, flipped Q1 parity sets it
      do_reset();
      send_frame(16'h1357, 16'h2468, 16'hACE1, 16'h8001, W, 1'b0);
      tick();
      check("par_ok_err",  64'(parity_err), 64'h0);
      check("par_ok_data", rd_data, 64'h8001_ACE1_2468_1357);
      send_frame(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000, W, 1'b1);
      tick();
      check("par_bad_err",  64'(parity_err), 64'h1);
      check("par_bad_data", rd_data, 64'h8000_FFFF_0001_A5C3);
      check("par_bad_cnt",  64'(frame_cnt), 64'h2);
      tick();
      check("par_sticky",   64'(parity_err), 64'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
